// File: rtl/score_pkg.sv
// score_pkg: shared types and constants for the score tracker.
// Game state encoding and BCD digit type.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_counter.sv
// bcd_counter: saturating multi-digit BCD accumulator.
// Adds 1 or 2 per update; an overflowing sum holds at all-9s.
module bcd_counter
  import score_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  add1,
  input  logic                  add2,
  output logic [4*DIGITS-1:0]   count,
  output logic [4*DIGITS-1:0]   next_count
);

  logic [4*DIGITS-1:0] nines;
  logic [4*DIGITS-1:0] sum_all;
  logic [4:0]          carry;
  logic [4:0]          dsum;

  // Ripple the increment through the digits, saturating on carry-out
  always_comb begin
    carry   = add2 ? 5'd2 : {4'd0, add1};
    sum_all = count;
    nines   = '0;
    dsum    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nines[4*i +: 4] = BCD_MAX_DIGIT;
      dsum = {1'b0, count[4*i +: 4]} + carry;
      if (dsum > 5'd9) begin
        sum_all[4*i +: 4] = 4'(dsum - 5'd10);
        carry = 5'd1;
      end else begin
        sum_all[4*i +: 4] = dsum[3:0];
        carry = 5'd0;
      end
    end
    next_count = (carry != 5'd0) ? nines : sum_all;
  end

  // Score register: cleared on reset or new game, updated on credit
  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (add1 || add2)
      count <= next_count;
  end

endmodule

// File: rtl/score_tracker.sv
// score_tracker: frame-synchronous scoring and game-state control.
// Coin credits, BCD score/high score, collision-driven game over.
module score_tracker
  import score_pkg::*;
#(
  parameter int DIGITS           = 4,
  parameter int OVER_HOLD_FRAMES = 120
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_v_sync,
  input  logic                i_start,
  input  logic                i_scored_left,
  input  logic                i_scored_right,
  input  logic                i_penguin_pixel,
  input  logic                i_obstacle_pixel,
  output logic [4*DIGITS-1:0] o_score,
  output logic [4*DIGITS-1:0] o_high_score,
  output logic [1:0]          o_state,
  output logic                o_score_pulse
);

  localparam int HW = $clog2(OVER_HOLD_FRAMES + 1);

  game_state_t         state;
  logic [HW-1:0]       hold;
  logic [1:0]          vs_sync;
  logic                vs_d;
  logic                frame_tick;
  logic                prev_l;
  logic                prev_r;
  logic                primed;
  logic                hit;
  logic                hit_set;
  logic                collide;
  logic                credit_l;
  logic                credit_r;
  logic                go;
  logic [4*DIGITS-1:0] next_score;

  assign frame_tick = vs_sync[1] & ~vs_d;
  assign hit_set    = (state == PLAY) & i_penguin_pixel & i_obstacle_pixel;
  assign collide    = hit | hit_set;
  // primed blocks a credit on the first tick after a start, so a coin
  // that is already high when the game begins is only sampled
  assign credit_l   = frame_tick & (state == PLAY) & primed
                    & i_scored_left & ~prev_l;
  assign credit_r   = frame_tick & (state == PLAY) & primed
                    & i_scored_right & ~prev_r;
  assign go         = i_start & ((state == IDLE)
                    | ((state == OVER) & (hold == '0)));
  assign o_state    = state;

  bcd_counter #(.DIGITS(DIGITS)) u_count (
    .clk        (i_clk),
    .reset      (i_reset),
    .clear      (go),
    .add1       (credit_l ^ credit_r),
    .add2       (credit_l & credit_r),
    .count      (o_score),
    .next_count (next_score)
  );

  // v_sync synchronizer and rising-edge detector
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vs_sync <= '0;
      vs_d    <= 1'b0;
    end else begin
      vs_sync <= {vs_sync[0], i_v_sync};
      vs_d    <= vs_sync[1];
    end
  end

  // Game FSM, coin sampling, collision flag and high score
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state         <= IDLE;
      hold          <= '0;
      prev_l        <= 1'b0;
      prev_r        <= 1'b0;
      primed        <= 1'b0;
      hit           <= 1'b0;
      o_high_score  <= '0;
      o_score_pulse <= 1'b0;
    end else begin
      o_score_pulse <= credit_l | credit_r;
      if (frame_tick) begin
        prev_l <= i_scored_left;
        prev_r <= i_scored_right;
        primed <= 1'b1;
        hit    <= 1'b0;
      end else if (hit_set) begin
        hit <= 1'b1;
      end
      unique case (state)
        IDLE: ;
        PLAY: begin
          if (frame_tick && collide) begin
            state <= OVER;
            hold  <= HW'(OVER_HOLD_FRAMES);
            // valid BCD orders the same as plain binary
            if (next_score > o_high_score)
              o_high_score <= next_score;
          end
        end
        OVER: begin
          if (frame_tick && hold != '0)
            hold <= hold - HW'(1);
        end
        default: state <= IDLE;
      endcase
      if (go) begin
        state  <= PLAY;
        hold   <= '0;
        hit    <= 1'b0;
        prev_l <= 1'b0;
        prev_r <= 1'b0;
        primed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_score_tracker.sv
// tb_score_tracker: directed checks of scoring, saturation,
// collision, game-over hold and reset for score_tracker.
module tb_score_tracker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v_sync = 1'b0;
  logic        start = 1'b0;
  logic        left = 1'b0;
  logic        right = 1'b0;
  logic        pen = 1'b0;
  logic        obs = 1'b0;
  logic [15:0] score;
  logic [15:0] high;
  logic [1:0]  state;
  logic        pulse;

  int total = 0;
  int passed = 0;
  int pulses = 0;

  score_tracker #(.DIGITS(4), .OVER_HOLD_FRAMES(120)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_v_sync         (v_sync),
    .i_start          (start),
    .i_scored_left    (left),
    .i_scored_right   (right),
    .i_penguin_pixel  (pen),
    .i_obstacle_pixel (obs),
    .o_score          (score),
    .o_high_score     (high),
    .o_state          (state),
    .o_score_pulse    (pulse)
  );

  always #5 clk = ~clk;

  task check(input string tag, input logic [31:0] got,
             input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s got %0h exp %0h", tag, got, exp);
  endtask

  task cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (pulse) pulses++;
    end
  endtask

  task frame(input int n);
    v_sync = 1'b1;
    cyc(n);
    v_sync = 1'b0;
    cyc(n);
  endtask

  task pstart();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
  endtask

  task bump();
    pen = 1'b1;
    obs = 1'b1;
    cyc(1);
    pen = 1'b0;
    obs = 1'b0;
    cyc(1);
  endtask

  initial begin
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rst_state", 32'(state), 0);
    check("rst_score", 32'(score), 0);
    check("rst_high", 32'(high), 0);
    check("rst_pulse", 32'(pulse), 0);

    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("start_state", 32'(state), 1);
    cyc(1);
    check("start_score", 32'(score), 0);

    frame(3);
    left = 1'b1;
    pulses = 0;
    repeat (5) frame(3);
    check("hold5_score", 32'(score), 32'h0001);
    check("hold5_pulses", 32'(pulses), 1);

    repeat (4) begin
      left = 1'b0;
      frame(3);
      left = 1'b1;
      frame(3);
    end
    check("score5", 32'(score), 32'h0005);
    left = 1'b0;
    frame(3);
    left = 1'b1;
    right = 1'b1;
    pulses = 0;
    frame(3);
    check("dual_score", 32'(score), 32'h0007);
    check("dual_pulses", 32'(pulses), 1);

    left = 1'b0;
    right = 1'b0;
    frame(3);
    left = 1'b1;
    bump();
    v_sync = 1'b1;
    cyc(2);
    check("pre_over", 32'(state), 1);
    cyc(1);
    check("over_state", 32'(state), 2);
    check("over_score", 32'(score), 32'h0008);
    check("over_high", 32'(high), 32'h0008);
    cyc(1);
    v_sync = 1'b0;
    cyc(3);

    repeat (50) frame(3);
    pstart();
    check("start_f50", 32'(state), 2);
    repeat (69) frame(3);
    pstart();
    check("start_f119", 32'(state), 2);
    frame(3);
    pstart();
    check("start_f120", 32'(state), 1);
    check("restart_score", 32'(score), 0);
    check("restart_high", 32'(high), 32'h0008);

    left = 1'b0;
    right = 1'b0;
    frame(2);
    repeat (4999) begin
      left = 1'b1;
      right = 1'b1;
      frame(2);
      left = 1'b0;
      right = 1'b0;
      frame(2);
    end
    check("score9998", 32'(score), 32'h9998);
    left = 1'b1;
    right = 1'b1;
    frame(2);
    check("sat_dual", 32'(score), 32'h9999);
    left = 1'b0;
    right = 1'b0;
    frame(2);
    left = 1'b1;
    frame(2);
    check("sat_hold", 32'(score), 32'h9999);
    left = 1'b0;
    frame(2);
    bump();
    frame(3);
    check("over2_state", 32'(state), 2);
    check("over2_high", 32'(high), 32'h9999);

    repeat (120) frame(3);
    pstart();
    check("replay_state", 32'(state), 1);
    check("replay_high", 32'(high), 32'h9999);
    frame(3);
    repeat (21) begin
      left = 1'b1;
      right = 1'b1;
      frame(3);
      left = 1'b0;
      right = 1'b0;
      frame(3);
    end
    check("score42", 32'(score), 32'h0042);
    reset = 1'b1;
    cyc(1);
    check("mid_rst_score", 32'(score), 0);
    check("mid_rst_high", 32'(high), 0);
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_pulse", 32'(pulse), 0);
    reset = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
